// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and the counter type shared by the
// sync controller and its counters.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_DISPLAY_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_DISPLAY_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  localparam int H_TOTAL_D      = H_DISPLAY_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D      = V_DISPLAY_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam int H_SYNC_START_D = H_DISPLAY_D + H_FRONT_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D - 1;
  localparam int V_SYNC_START_D = V_DISPLAY_D + V_FRONT_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D - 1;

  // True when pos lies in the inclusive window [lo, hi].
  function automatic logic in_window(input cnt_t pos, input cnt_t lo, input cnt_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; max_tick flags the terminal count N-1.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int N = 800
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output cnt_t count,
  output logic max_tick
);

  cnt_t count_q, count_d;

  assign max_tick = (count_q == cnt_t'(N - 1));
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (en) count_d = max_tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing: pixel/line counters, registered syncs aligned with the
// counters, combinational visible-area flag and a frame-start pulse.
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t HS_START = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_START = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  cnt_t h_cnt, v_cnt, h_nxt, v_nxt;
  logic h_max, v_max, v_en;
  logic hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

  assign v_en = tick & h_max;

  mod_counter #(.N(H_TOTAL)) u_hcnt (
    .clk(clk), .reset(reset), .en(tick), .count(h_cnt), .max_tick(h_max)
  );

  mod_counter #(.N(V_TOTAL)) u_vcnt (
    .clk(clk), .reset(reset), .en(v_en), .count(v_cnt), .max_tick(v_max)
  );

  // Syncs decode the counters' next values so they land on the same edge.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) h_nxt = h_max ? '0 : h_cnt + 1'b1;
    if (v_en) v_nxt = v_max ? '0 : v_cnt + 1'b1;
    hsync_d = ~in_window(h_nxt, HS_START, HS_END);
    vsync_d = ~in_window(v_nxt, VS_START, VS_END);
    fs_d    = tick & h_max & v_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign video_on    = (h_cnt < cnt_t'(H_DISPLAY)) && (v_cnt < cnt_t'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed/random bench for vga_sync_controller on a shrunken raster so whole
// frames fit in a short run; expectations come from raster arithmetic.
module tb_vga_sync_controller;

  localparam int HD = 16, HF = 4, HS = 6, HB = 4;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int n_cmp = 0, n_err = 0;
  int hx = 0, vy = 0;
  bit fs_m = 0;

  vga_sync_controller #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (model x=%0d y=%0d)", tag, obs, exp, hx, vy);
    end
  endtask

  task automatic check_all();
    check("pixel_x", 32'(pixel_x), hx);
    check("pixel_y", 32'(pixel_y), vy);
    check("hsync", 32'(hsync), 32'(!(hx >= HD + HF && hx < HD + HF + HS)));
    check("vsync", 32'(vsync), 32'(!(vy >= VD + VF && vy < VD + VF + VS)));
    check("video_on", 32'(video_on), 32'(hx < HD && vy < VD));
    check("frame_start", 32'(frame_start), 32'(fs_m));
  endtask

  // One clk with tick=t; model advances on the edge, outputs checked at negedge.
  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    fs_m = 0;
    if (reset) begin
      hx = 0; vy = 0;
    end else if (t) begin
      hx = (hx + 1) % HT;
      if (hx == 0) begin
        vy = (vy + 1) % VT;
        fs_m = (vy == 0);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  int hs_low, vs_low, fs_cnt;

  initial begin
    // Reset with tick toggling: everything parked at reset values.
    for (int i = 0; i < 6; i++) step(i[0]);

    reset = 1'b0;
    step(1'b1);
    check("first_tick_x", 32'(pixel_x), 1);

    // One line with a tick every 4th clk; count hsync-low pixels.
    hs_low = 0;
    for (int i = 0; i < HT; i++) begin
      step(1'b1);
      if (!hsync) hs_low++;
      if (hx == HD) check("video_off_at_HD", 32'(video_on), 0);
      if (hx == HD + HF) check("hsync_start", 32'(hsync), 0);
      for (int j = 0; j < 3; j++) step(1'b0);
    end
    check("hsync_width", hs_low, HS);

    // Line wrap at (HT-1, 10) -> (0, 11) on one edge.
    for (int i = 0; i < 2 * HT * VT && !(hx == HT - 1 && vy == 10); i++) step(1'b1);
    check("reach_wrap_pt", 32'(pixel_x == 10'(HT - 1) && pixel_y == 10'd10), 1);
    step(1'b1);
    check("wrap_x", 32'(pixel_x), 0);
    check("wrap_y", 32'(pixel_y), 11);

    // Continuous tick for three frames.
    fs_cnt = 0; vs_low = 0;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      step(1'b1);
      if (frame_start) begin
        fs_cnt++;
        check("fs_at_origin", 32'(pixel_x == 0 && pixel_y == 0), 1);
      end
      if (!vsync) vs_low++;
    end
    check("frame_pulses", fs_cnt, 3);
    check("vsync_low_px", vs_low, 3 * VS * HT);

    // Irregular tick gaps of 1..7 idle clk.
    for (int i = 0; i < HT * VT + 50; i++) begin
      step(1'b1);
      repeat ($urandom_range(7, 1)) step(1'b0);
    end

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 2 * HT * VT && !(hx == 12 && vy == 5); i++) step(1'b1);
    check("reach_mid", 32'(pixel_x == 10'd12 && pixel_y == 10'd5), 1);
    tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    hx = 0; vy = 0; fs_m = 0;
    check_all();
    @(negedge clk);
    step(1'b1);
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
    step(1'b1);
    check("resume_x", 32'(pixel_x), 1);
    for (int i = 0; i < 200; i++) step(1'($urandom_range(1, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
